// File: rtl/dp_pkg.sv
// Shared datapath types and width helpers for the convolution MAC pipeline.
package dp_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_flags_t;

  function automatic int unsigned prod_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned leaves);
    return 2 * data_width + $clog2(leaves);
  endfunction

  // Two same-signed operands producing an opposite-signed result cannot be a true sum.
  function automatic logic add_overflow(input logic a_sign, input logic b_sign,
                                        input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Combinational signed reduction of LEAVES products into one OUT_W-bit sum.
module conv_adder_tree #(
  parameter int unsigned LEAVES = 18,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 21
) (
  input  logic [LEAVES-1:0][IN_W-1:0] leaves,
  output logic [OUT_W-1:0]            sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LEAVES; i++) begin
      sum = sum + OUT_W'($signed(leaves[i]));
    end
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Three-stage signed MAC for one OFM lane: products, adder tree, accumulate and emit.
module conv_mac_pipe
  import dp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PARALLEL_IFM  = 2,
  parameter int unsigned KERNEL_WIDTH  = 3,
  parameter int unsigned KERNEL_HEIGHT = 3,
  parameter int unsigned ACC_WIDTH     = 24
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PARALLEL_IFM-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] in_window,
  input  logic [PARALLEL_IFM-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] in_weight,
  input  logic [PARALLEL_IFM-1:0] pifm_active,
  input  logic                   acc_first,
  input  logic                   acc_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_psum,
  output logic                   out_overflow
);

  localparam int unsigned LEAVES = PARALLEL_IFM * KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int unsigned PROD_W = prod_width(DATA_WIDTH);
  localparam int unsigned SUM_W  = sum_width(DATA_WIDTH, LEAVES);

  logic                           advance;
  stage_flags_t                   s1_flags, s2_flags;
  logic [LEAVES-1:0][PROD_W-1:0]  prod_next, s1_prod;
  logic [SUM_W-1:0]               tree_sum;
  logic [ACC_WIDTH-1:0]           s2_sum;
  logic [ACC_WIDTH-1:0]           acc, acc_add, acc_next;
  logic                           acc_ovf, ovf_next;
  logic signed [PROD_W-1:0]       op_a, op_b;

  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance;
  end

  always_comb begin
    prod_next = '0;
    op_a      = '0;
    op_b      = '0;
    for (int unsigned c = 0; c < PARALLEL_IFM; c++) begin
      for (int unsigned r = 0; r < KERNEL_HEIGHT; r++) begin
        for (int unsigned k = 0; k < KERNEL_WIDTH; k++) begin
          op_a = PROD_W'($signed(in_window[c][r][k]));
          op_b = PROD_W'($signed(in_weight[c][r][k]));
          if (pifm_active[c])
            prod_next[(c * KERNEL_HEIGHT + r) * KERNEL_WIDTH + k] = op_a * op_b;
        end
      end
    end
  end

  conv_adder_tree #(
    .LEAVES(LEAVES),
    .IN_W  (PROD_W),
    .OUT_W (SUM_W)
  ) u_tree (
    .leaves(s1_prod),
    .sum   (tree_sum)
  );

  always_comb begin
    acc_add = acc + s2_sum;
    if (s2_flags.first) begin
      acc_next = s2_sum;
      ovf_next = 1'b0;
    end else begin
      acc_next = acc_add;
      ovf_next = acc_ovf | add_overflow(acc[ACC_WIDTH-1], s2_sum[ACC_WIDTH-1],
                                        acc_add[ACC_WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_flags     <= '0;
      s1_prod      <= '0;
      s2_flags     <= '0;
      s2_sum       <= '0;
      acc          <= '0;
      acc_ovf      <= 1'b0;
      out_valid    <= 1'b0;
      out_psum     <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (advance) begin
        s1_flags <= '{valid: in_valid, first: acc_first, last: acc_last};
        s1_prod  <= prod_next;
        s2_flags <= s1_flags;
        s2_sum   <= ACC_WIDTH'($signed(tree_sum));
        if (s2_flags.valid) begin
          acc     <= acc_next;
          acc_ovf <= ovf_next;
          if (s2_flags.last) begin
            out_psum     <= acc_next;
            out_overflow <= ovf_next;
          end
        end
      end
      // A committing last beat wins over the handshake that would clear out_valid.
      if (advance && s2_flags.valid && s2_flags.last)
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Self-checking bench for conv_mac_pipe: directed cases plus randomized traffic against a pass-level model.
module tb_conv_mac_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned PI = 2;
  localparam int unsigned KW = 3;
  localparam int unsigned KH = 3;
  localparam int unsigned AW = 24;
  localparam longint HALF = longint'(1) <<< (AW - 1);

  logic clk = 1'b0;
  logic arst_n;
  logic in_valid, in_ready, acc_first, acc_last;
  logic out_valid, out_ready, out_overflow;
  logic [PI-1:0][KH-1:0][KW-1:0][DW-1:0] in_window, in_weight;
  logic [PI-1:0] pifm_active;
  logic [AW-1:0] out_psum;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_emit   = 0;
  longint exp_q[$];
  bit     ovf_q[$];
  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  longint e_psum;
  bit     e_ovf;

  always #5 clk = ~clk;

  conv_mac_pipe #(
    .DATA_WIDTH   (DW),
    .PARALLEL_IFM (PI),
    .KERNEL_WIDTH (KW),
    .KERNEL_HEIGHT(KH),
    .ACC_WIDTH    (AW)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_window   (in_window),
    .in_weight   (in_weight),
    .pifm_active (pifm_active),
    .acc_first   (acc_first),
    .acc_last    (acc_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_psum    (out_psum),
    .out_overflow(out_overflow)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint beat_sum();
    longint s = 0;
    for (int c = 0; c < PI; c++)
      if (pifm_active[c])
        for (int r = 0; r < KH; r++)
          for (int k = 0; k < KW; k++)
            s += longint'($signed(in_window[c][r][k])) * longint'($signed(in_weight[c][r][k]));
    return s;
  endfunction

  // Pass-level model: true running sum, wrapped into AW bits, overflow when out of range.
  task automatic model_accept();
    longint s, t;
    s = beat_sum();
    if (acc_first) begin
      m_acc = s;
      m_ovf = 1'b0;
    end else begin
      t = m_acc + s;
      if (t >= HALF || t < -HALF) m_ovf = 1'b1;
      if (t >= HALF) t -= 2 * HALF;
      else if (t < -HALF) t += 2 * HALF;
      m_acc = t;
    end
    if (acc_last) begin
      exp_q.push_back(m_acc);
      ovf_q.push_back(m_ovf);
    end
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      if (out_valid && out_ready) begin
        n_emit++;
        check("pending_result", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_psum = exp_q.pop_front();
          e_ovf  = ovf_q.pop_front();
          check("psum", longint'($signed(out_psum)), e_psum);
          check("ovf", longint'(out_overflow), longint'(e_ovf));
        end
      end
      if (in_valid && in_ready) model_accept();
    end
  end

  task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] w, input logic [PI-1:0] act);
    for (int c = 0; c < PI; c++)
      for (int r = 0; r < KH; r++)
        for (int k = 0; k < KW; k++) begin
          in_window[c][r][k] = a;
          in_weight[c][r][k] = w;
        end
    pifm_active = act;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic f, input logic l);
    int n = 0;
    in_valid  = 1'b1;
    acc_first = f;
    acc_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    check("send_accept", longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({tag, "_valid"}, longint'(out_valid), 1);
  endtask

  initial begin
    int n, e0;
    arst_n    = 1'b0;
    in_valid  = 1'b0;
    acc_first = 1'b0;
    acc_last  = 1'b0;
    out_ready = 1'b1;
    fill(8'd0, 8'd0, '1);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_psum", longint'(out_psum), 0);
    check("rst_ovf", longint'(out_overflow), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    step();

    // single beat, all ones
    fill(8'd1, 8'd1, '1);
    send_beat(1'b1, 1'b1);
    wait_out("single", n);
    check("single_latency", n, 3);
    check("single_psum", longint'($signed(out_psum)), 18);
    check("single_ovf", longint'(out_overflow), 0);
    step();

    // three-beat pass
    e0 = n_emit;
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b1);
    wait_out("pass3", n);
    check("pass3_psum", longint'($signed(out_psum)), 54);
    repeat (3) step();
    check("pass3_emits", n_emit - e0, 1);

    // extreme values and a disabled channel
    fill(8'd127, 8'h80, '1);
    send_beat(1'b1, 1'b1);
    wait_out("extreme", n);
    check("extreme_psum", longint'($signed(out_psum)), -292608);
    step();
    fill(8'd1, 8'd1, 2'b01);
    send_beat(1'b1, 1'b1);
    wait_out("masked", n);
    check("masked_psum", longint'($signed(out_psum)), 9);
    step();

    // backpressure with input pending
    e0 = n_emit;
    out_ready = 1'b0;
    fill(8'd1, 8'd1, '1);
    send_beat(1'b1, 1'b1);
    fill(8'd2, 8'd3, '1);
    send_beat(1'b1, 1'b1);
    wait_out("stall", n);
    step();
    fill(8'd1, 8'd1, 2'b01);
    in_valid  = 1'b1;
    acc_first = 1'b1;
    acc_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_out_valid", longint'(out_valid), 1);
      check("stall_psum", longint'($signed(out_psum)), 18);
    end
    step();
    out_ready = 1'b1;
    send_beat(1'b1, 1'b1);
    repeat (8) step();
    check("stall_emits", n_emit - e0, 3);
    check("stall_drained", exp_q.size(), 0);

    // long pass wrapping the accumulator
    fill(8'd127, 8'h80, '1);
    send_beat(1'b1, 1'b0);
    for (int i = 0; i < 27; i++) send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b1);
    wait_out("wrap", n);
    check("wrap_psum", longint'($signed(out_psum)), 8291584);
    check("wrap_ovf", longint'(out_overflow), 1);
    step();
    fill(8'd1, 8'd1, '1);
    send_beat(1'b1, 1'b1);
    wait_out("after_wrap", n);
    check("after_wrap_psum", longint'($signed(out_psum)), 18);
    check("after_wrap_ovf", longint'(out_overflow), 0);
    step();

    // reset with a held result and two beats in flight
    out_ready = 1'b0;
    fill(8'd2, 8'd3, '1);
    send_beat(1'b1, 1'b1);
    fill(8'd1, 8'd1, '1);
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    wait_out("pre_reset", n);
    check("pre_reset_psum", longint'($signed(out_psum)), 108);
    #2 arst_n = 1'b0;
    #1;
    check("arst_out_valid", longint'(out_valid), 0);
    check("arst_psum", longint'(out_psum), 0);
    check("arst_ovf", longint'(out_overflow), 0);
    check("arst_in_ready", longint'(in_ready), 1);
    exp_q.delete();
    ovf_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    step();
    arst_n    = 1'b1;
    out_ready = 1'b1;
    step();
    // a continuation beat exposes whether the accumulator really cleared
    send_beat(1'b0, 1'b1);
    wait_out("post_reset_cont", n);
    check("post_reset_cont_psum", longint'($signed(out_psum)), 18);
    step();
    send_beat(1'b1, 1'b1);
    wait_out("post_reset", n);
    check("post_reset_psum", longint'($signed(out_psum)), 18);
    step();

    // randomized traffic with bubbles and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      acc_first   = ($urandom_range(0, 3) == 0);
      acc_last    = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      pifm_active = PI'($urandom);
      for (int c = 0; c < PI; c++)
        for (int r = 0; r < KH; r++)
          for (int k = 0; k < KW; k++) begin
            in_window[c][r][k] = DW'($urandom);
            in_weight[c][r][k] = DW'($urandom);
          end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    check("random_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
